mpsoc_mem_arbiter: RTL and testbench
====================================

MPSOC_MEM_ARBITER -- requirements
Module: mpsoc_mem_arbiter

Interface
REQ-001 ADDR_W, default 11, word-address width shared by both masters and the memory port.
REQ-002 DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 mN_address (N=0,1)  in  ADDR_W  master N word address.
REQ-006 mN_byteenable  in  DATA_W/8  master N byte lanes.
REQ-007 mN_read  in  1  master N read request.
REQ-008 mN_write  in  1  master N write request.
REQ-009 mN_writedata  in  DATA_W  master N write data.
REQ-010 mN_waitrequest  out  1  high = master N request not accepted this cycle.
REQ-011 mN_readdata  out  DATA_W  master N read data.
REQ-012 mN_readdatavalid  out  1  master N readdata qualifier, one pulse per accepted read.
REQ-013 mem_address  out  ADDR_W  to single-port RAM.
REQ-014 mem_byteenable  out  DATA_W/8  to RAM.
REQ-015 mem_chipselect  out  1  to RAM.
REQ-016 mem_write  out  1  to RAM.
REQ-017 mem_writedata  out  DATA_W  to RAM.
REQ-018 mem_clken  out  1  RAM clock enable; tied high except during reset.
REQ-019 mem_readdata  in  DATA_W  RAM output, valid one cycle after address presented.

Function
REQ-020 Request of master N: reqN = mN_read | mN_write; simultaneous read and write from one master SHALL be treated as write only.
REQ-021 At most one master SHALL be granted per cycle; grant is combinational from reqN and registered last_grant.
REQ-022 Round-robin: both requesting -> grant master != last_grant; one requesting -> grant it; none -> no grant, last_grant unchanged.
REQ-023 last_grant SHALL update to the granted master at the clock edge ending a granted cycle.
REQ-024 mN_waitrequest = reqN & ~grantN; a non-requesting master SHALL see waitrequest low.
REQ-025 Granted cycle: mem_chipselect=1, mem_address/byteenable/writedata from granted master, mem_write=granted master's write; no grant: mem_chipselect=0, mem_write=0.
REQ-026 Accepted read SHALL produce mN_readdatavalid=1 for exactly the next cycle with mN_readdata=mem_readdata; fixed latency 1, back-to-back reads supported at one per cycle.
REQ-027 rd_pending/rd_owner registers SHALL track the outstanding read; readdatavalid of the non-owner SHALL stay 0; mN_readdata SHALL be 0 when not valid.
REQ-028 Writes complete in the granted cycle; no response beat.
REQ-029 byteenable=0 write SHALL be forwarded unchanged (no memory effect, still consumes the grant).
REQ-030 Worst-case wait for a requesting master without lock: 1 cycle.

Reset
REQ-031 reset_n low SHALL asynchronously clear: last_grant=1 (master 0 wins first contention), rd_pending=0, lock state=0.
REQ-032 During reset: all waitrequest=1, readdatavalid=0, readdata=0, mem_chipselect=0, mem_write=0, mem_clken=0.
REQ-033 Reset mid-read SHALL discard the pending readdatavalid; no pulse after release.

Configuration
REQ-034 Macro MEM_ARB_LOCK_EN SHALL, when defined, add inputs m0_lock, m1_lock (1 bit).
REQ-035 With MEM_ARB_LOCK_EN: granted transfer with mN_lock=1 SHALL hold grant on master N (other master waits) until master N completes a granted transfer with lock=0; locked master idle SHALL keep ownership.
REQ-036 Without MEM_ARB_LOCK_EN: lock ports absent, pure round-robin per REQ-022.

Verification
REQ-037 Reset release, m0 write 0x0A5=0xDEADBEEF, then m0 read 0x0A5 -> m0_readdatavalid one cycle after accept, readdata 0xDEADBEEF, m1 signals idle.
REQ-038 Both masters read every cycle for 8 cycles -> grants alternate 0,1,0,1...; each master gets 4 readdatavalid pulses, correctly routed.
REQ-039 m1 write byteenable=0x3 data 0x12345678 to 0x7FF over 0xFFFFFFFF -> read back 0xFFFF5678 (address wrap top).
REQ-040 reset_n asserted the cycle after m0 read accept -> no readdatavalid; after release first contention grants m0.
REQ-041 MEM_ARB_LOCK_EN: m1 issues 3 locked writes then unlocked write while m0 reads continuously -> m0 waitrequest high for all 4 m1 transfers, then m0 granted.
REQ-042 m0 read+write same cycle, address 0x010, data 0x55 -> write performed, no readdatavalid.

Source files
------------

// File: rtl/mpsoc_mem_arbiter_if.sv
// rtl/mpsoc_mem_arbiter_if.sv - memory-mapped master bus bundle for one arbiter port
interface mpsoc_mem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/mpsoc_mem_arbiter.sv
// rtl/mpsoc_mem_arbiter.sv - two-master round-robin arbiter onto one single-port RAM
// Optional grant locking is compiled in with MEM_ARB_LOCK_EN.
module mpsoc_mem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
`ifdef MEM_ARB_LOCK_EN
  input  logic                m0_lock,
  input  logic                m1_lock,
`endif
  mpsoc_mem_arbiter_if.slave  m0,
  mpsoc_mem_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic req0;
  logic req1;
  logic gnt_valid;
  logic gnt_sel;
  logic gnt_write;
  logic hold_valid;
  logic hold_sel;

  logic last_grant_q, last_grant_d;
  logic rd_pending_q, rd_pending_d;
  logic rd_owner_q,   rd_owner_d;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

`ifdef MEM_ARB_LOCK_EN
  typedef enum logic [1:0] {
    LK_OPEN  = 2'd0,
    LK_HOLD0 = 2'd1,
    LK_HOLD1 = 2'd2
  } lock_state_e;

  lock_state_e lock_q, lock_d;
  logic        gnt_lock;

  assign gnt_lock = gnt_sel ? m1_lock : m0_lock;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q <= LK_OPEN;
    end else begin
      lock_q <= lock_d;
    end
  end

  // Ownership only changes on a granted transfer; an idle owner keeps it.
  always_comb begin
    lock_d = lock_q;
    if (gnt_valid) begin
      if (gnt_lock) begin
        lock_d = gnt_sel ? LK_HOLD1 : LK_HOLD0;
      end else begin
        lock_d = LK_OPEN;
      end
    end
  end

  assign hold_valid = (lock_q != LK_OPEN);
  assign hold_sel   = (lock_q == LK_HOLD1);
`else
  assign hold_valid = 1'b0;
  assign hold_sel   = 1'b0;
`endif

  // Contention goes to the master that was not served last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_sel   = 1'b0;
    if (hold_valid) begin
      gnt_sel   = hold_sel;
      gnt_valid = hold_sel ? req1 : req0;
    end else if (req0 && req1) begin
      gnt_valid = 1'b1;
      gnt_sel   = ~last_grant_q;
    end else if (req1) begin
      gnt_valid = 1'b1;
      gnt_sel   = 1'b1;
    end else if (req0) begin
      gnt_valid = 1'b1;
      gnt_sel   = 1'b0;
    end
    if (!reset_n) begin
      gnt_valid = 1'b0;
    end
  end

  assign gnt_write = gnt_sel ? m1.write : m0.write;

  assign mem_chipselect = gnt_valid;
  assign mem_write      = gnt_valid & gnt_write;
  assign mem_address    = gnt_sel ? m1.address    : m0.address;
  assign mem_byteenable = gnt_sel ? m1.byteenable : m0.byteenable;
  assign mem_writedata  = gnt_sel ? m1.writedata  : m0.writedata;
  assign mem_clken      = reset_n;

  assign m0.waitrequest = ~reset_n | (req0 & ~(gnt_valid & ~gnt_sel));
  assign m1.waitrequest = ~reset_n | (req1 & ~(gnt_valid &  gnt_sel));

  always_comb begin
    last_grant_d = last_grant_q;
    rd_owner_d   = rd_owner_q;
    rd_pending_d = gnt_valid & ~gnt_write;
    if (gnt_valid) begin
      last_grant_d = gnt_sel;
      rd_owner_d   = gnt_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign m0.readdatavalid = rd_pending_q & ~rd_owner_q;
  assign m1.readdatavalid = rd_pending_q &  rd_owner_q;
  assign m0.readdata      = m0.readdatavalid ? mem_readdata : '0;
  assign m1.readdata      = m1.readdatavalid ? mem_readdata : '0;

endmodule

// File: tb/tb_mpsoc_mem_arbiter.sv
// tb/tb_mpsoc_mem_arbiter.sv - randomized bench for mpsoc_mem_arbiter against a transaction-level model
module tb_mpsoc_mem_arbiter;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef MEM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mpsoc_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  mpsoc_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  logic              m0_lock;
  logic              m1_lock;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  mpsoc_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
`ifdef MEM_ARB_LOCK_EN
    .m0_lock        (m0_lock),
    .m1_lock        (m1_lock),
`endif
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  // Single-port RAM with one cycle read latency.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < BE_W; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                last_served;
  int                lock_owner;
  bit                exp_v [2];
  logic [DATA_W-1:0] exp_d [2];
  int                rdv_seen [2];

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_served = 1;
    lock_owner  = -1;
    exp_v[0] = 1'b0;
    exp_v[1] = 1'b0;
  endtask

  // One bus cycle: entered and left at posedge+1, outputs sampled at the falling edge.
  task automatic step(
    input bit r0, input bit w0, input logic [ADDR_W-1:0] a0, input logic [BE_W-1:0] be0,
    input logic [DATA_W-1:0] d0, input bit l0,
    input bit r1, input bit w1, input logic [ADDR_W-1:0] a1, input logic [BE_W-1:0] be1,
    input logic [DATA_W-1:0] d1, input bit l1);
    int g;
    bit q0, q1, gw;
    logic [ADDR_W-1:0] ga;
    logic [BE_W-1:0]   gbe;
    logic [DATA_W-1:0] gd;
    m0_if.read = r0; m0_if.write = w0; m0_if.address = a0; m0_if.byteenable = be0; m0_if.writedata = d0;
    m1_if.read = r1; m1_if.write = w1; m1_if.address = a1; m1_if.byteenable = be1; m1_if.writedata = d1;
    m0_lock = l0;
    m1_lock = l1;
    q0 = r0 | w0;
    q1 = r1 | w1;
    g = -1;
    if (lock_owner >= 0) begin
      if ((lock_owner == 0 && q0) || (lock_owner == 1 && q1)) g = lock_owner;
    end else if (q0 && q1) g = 1 - last_served;
    else if (q0) g = 0;
    else if (q1) g = 1;
    gw  = (g == 1) ? w1  : w0;
    ga  = (g == 1) ? a1  : a0;
    gbe = (g == 1) ? be1 : be0;
    gd  = (g == 1) ? d1  : d0;

    @(negedge clk);
    check("m0_wait", 32'(m0_if.waitrequest), 32'(q0 && g != 0));
    check("m1_wait", 32'(m1_if.waitrequest), 32'(q1 && g != 1));
    check("cs",      32'(mem_chipselect),    32'(g >= 0));
    check("clken",   32'(mem_clken),         32'd1);
    check("m0_rdv",  32'(m0_if.readdatavalid), 32'(exp_v[0]));
    check("m1_rdv",  32'(m1_if.readdatavalid), 32'(exp_v[1]));
    check("m0_rdata", m0_if.readdata, exp_v[0] ? exp_d[0] : '0);
    check("m1_rdata", m1_if.readdata, exp_v[1] ? exp_d[1] : '0);
    if (g >= 0) begin
      check("mem_wr",   32'(mem_write),      32'(gw));
      check("mem_addr", 32'(mem_address),    32'(ga));
      check("mem_be",   32'(mem_byteenable), 32'(gbe));
      if (gw) check("mem_wdata", mem_writedata, gd);
    end else begin
      check("mem_wr_idle", 32'(mem_write), 32'd0);
    end
    if (m0_if.readdatavalid) rdv_seen[0]++;
    if (m1_if.readdatavalid) rdv_seen[1]++;

    exp_v[0] = 1'b0;
    exp_v[1] = 1'b0;
    if (g >= 0) begin
      last_served = g;
      if (gw) begin
        for (int b = 0; b < BE_W; b++)
          if (gbe[b]) ref_mem[ga][8*b +: 8] = gd[8*b +: 8];
      end else begin
        exp_v[g] = 1'b1;
        exp_d[g] = ref_mem[ga];
      end
      if (LOCK_EN) lock_owner = ((g == 1) ? l1 : l0) ? g : -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, '0, '0, 0, 0, 0, '0, '0, '0, 0);
  endtask

  // Asserted at posedge+1 so the asynchronous clear is seen mid-cycle.
  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_m0_wait", 32'(m0_if.waitrequest),   32'd1);
    check("rst_m1_wait", 32'(m1_if.waitrequest),   32'd1);
    check("rst_m0_rdv",  32'(m0_if.readdatavalid), 32'd0);
    check("rst_m1_rdv",  32'(m1_if.readdatavalid), 32'd0);
    check("rst_m0_rd",   m0_if.readdata,           '0);
    check("rst_cs",      32'(mem_chipselect),      32'd0);
    check("rst_wr",      32'(mem_write),           32'd0);
    check("rst_clken",   32'(mem_clken),           32'd0);
    repeat (cycles) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    mem_readdata = '0;
    m0_lock = 1'b0;
    m1_lock = 1'b0;
    m0_if.read = 1'b1; m0_if.write = 1'b0; m0_if.address = '0; m0_if.byteenable = '1; m0_if.writedata = '0;
    m1_if.read = 1'b0; m1_if.write = 1'b0; m1_if.address = '0; m1_if.byteenable = '1; m1_if.writedata = '0;
    rdv_seen[0] = 0;
    rdv_seen[1] = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(2);

    // Write then read back through master 0.
    step(0, 1, 11'h0A5, 4'hF, 32'hDEADBEEF, 0, 0, 0, '0, '0, '0, 0);
    step(1, 0, 11'h0A5, 4'hF, '0, 0, 0, 0, '0, '0, '0, 0);
    idle();

    // Read+write together is a write only.
    step(1, 1, 11'h010, 4'hF, 32'h55, 0, 0, 0, '0, '0, '0, 0);
    idle();
    step(1, 0, 11'h010, 4'hF, '0, 0, 0, 0, '0, '0, '0, 0);
    idle();

    // Partial-lane and zero-lane writes at the top address.
    step(0, 0, '0, '0, '0, 0, 0, 1, 11'h7FF, 4'hF, 32'hFFFFFFFF, 0);
    step(0, 0, '0, '0, '0, 0, 0, 1, 11'h7FF, 4'h3, 32'h12345678, 0);
    step(0, 1, 11'h7FF, 4'h0, 32'h0, 0, 0, 0, '0, '0, '0, 0);
    step(0, 0, '0, '0, '0, 0, 1, 0, 11'h7FF, 4'hF, '0, 0);
    idle();
    check("top_word", ref_mem[11'h7FF], 32'hFFFF5678);

    // Continuous contention alternates grants.
    do_reset(1);
    rdv_seen[0] = 0;
    rdv_seen[1] = 0;
    for (int i = 0; i < 8; i++)
      step(1, 0, 11'h0A5, 4'hF, '0, 0, 1, 0, 11'h7FF, 4'hF, '0, 0);
    idle();
    check("m0_rdv_count", 32'(rdv_seen[0]), 32'd4);
    check("m1_rdv_count", 32'(rdv_seen[1]), 32'd4);

    // Reset one cycle after a read accept drops the response.
    step(1, 0, 11'h0A5, 4'hF, '0, 0, 0, 0, '0, '0, '0, 0);
    do_reset(2);
    idle();
    step(1, 0, 11'h010, 4'hF, '0, 0, 1, 0, 11'h0A5, 4'hF, '0, 0);
    idle();

`ifdef MEM_ARB_LOCK_EN
    step(1, 0, 11'h0A5, 4'hF, '0, 0, 0, 0, '0, '0, '0, 0);
    for (int i = 0; i < 4; i++)
      step(1, 0, 11'h0A5, 4'hF, '0, 0, 0, 1, 11'(20 + i), 4'hF, 32'(i), (i < 3));
    step(1, 0, 11'h0A5, 4'hF, '0, 0, 0, 0, '0, '0, '0, 0);
    idle();
`endif

    for (int i = 0; i < 400; i++) begin
      bit r0, w0, r1, w1, l0, l1;
      logic [ADDR_W-1:0] a0, a1;
      r0 = ($urandom_range(0, 9) < 5);
      w0 = ($urandom_range(0, 9) < 3);
      r1 = ($urandom_range(0, 9) < 5);
      w1 = ($urandom_range(0, 9) < 3);
      l0 = LOCK_EN && ($urandom_range(0, 3) == 0);
      l1 = LOCK_EN && ($urandom_range(0, 3) == 0);
      a0 = ($urandom_range(0, 8) == 8) ? 11'h7FF : 11'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 8) == 8) ? 11'h7FF : 11'($urandom_range(0, 7));
      step(r0, w0, a0, 4'($urandom), $urandom, l0, r1, w1, a1, 4'($urandom), $urandom, l1);
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
